forward_stall_unit: RTL and testbench

FORWARD_STALL_UNIT -- requirements
Module: forward_stall_unit

---
 rtl/forward_stall_unit.sv | 147 ++++++++++++++
 tb/tb_forward_stall_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/forward_stall_unit.sv
// rtl/forward_stall_unit.sv - operand forwarding select and issue stall control for an ID/EX/MEM/WB pipe
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   id_valid            ID holds an instruction offered for issue
//   id_rs               NUM_SRC packed source addresses, source i at [i*REG_AW +: REG_AW]
//   id_rd               destination address of the ID instruction
//   id_reg_write        ID instruction writes id_rd
//   id_is_load          ID instruction is a load (result only available from WB)
//   id_is_multi         ID instruction occupies EX for MULTI_LAT cycles
//   ex_flush            squash the ID instruction and the EX contents
//   id_ready            ID instruction accepted this cycle
//   fwd_sel             per-source EX operand select: 00 regfile, 01 WB, 10 MEM
//   ex_busy             EX holds a multi-cycle op with cycles remaining
//   stall_count         saturating count of cycles with id_valid=1 and id_ready=0

module forward_stall_unit #(
  parameter int NUM_SRC   = 2,
  parameter int REG_AW    = 5,
  parameter int MULTI_LAT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_is_load,
  input  logic                      id_is_multi,
  input  logic                      ex_flush,
  output logic                      id_ready,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      ex_busy,
  output logic [31:0]               stall_count
);

  localparam logic [3:0]        MULTI_INIT = 4'(MULTI_LAT - 1);
  localparam logic [REG_AW-1:0] ZERO_REG   = '0;

  // stage tags
  logic                      ex_valid, ex_reg_write, ex_is_load;
  logic [REG_AW-1:0]         ex_rd;
  logic [NUM_SRC*REG_AW-1:0] ex_rs;
  logic                      mem_valid, mem_reg_write, mem_is_load;
  logic [REG_AW-1:0]         mem_rd;
  logic                      wb_valid, wb_reg_write;
  logic [REG_AW-1:0]         wb_rd;

  logic [3:0]  multi_cnt;
  logic [31:0] stall_cnt_q;

  logic busy_q;
  logic load_use;

  assign busy_q = (multi_cnt != 4'd0);

  // A load sitting in EX cannot feed the ID instruction; hold ID one cycle so
  // the load reaches WB by the time the consumer is in EX.
  always_comb begin
    load_use = 1'b0;
    if (id_valid && ex_valid && ex_is_load && ex_reg_write && (ex_rd != ZERO_REG)) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (id_rs[i*REG_AW +: REG_AW] == ex_rd) load_use = 1'b1;
      end
    end
  end

  // A flush always accepts (and discards) the ID slot.
  assign id_ready    = !rst && (ex_flush || !(busy_q || load_use));
  assign ex_busy     = !rst && busy_q;
  assign stall_count = rst ? 32'd0 : stall_cnt_q;

  // MEM wins over WB as the younger producer; loads never forward from MEM.
  always_comb begin
    fwd_sel = '0;
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (ex_rs[i*REG_AW +: REG_AW] != ZERO_REG) begin
          if (mem_valid && mem_reg_write && !mem_is_load &&
              (mem_rd == ex_rs[i*REG_AW +: REG_AW]))
            fwd_sel[2*i +: 2] = 2'b10;
          else if (wb_valid && wb_reg_write && (wb_rd == ex_rs[i*REG_AW +: REG_AW]))
            fwd_sel[2*i +: 2] = 2'b01;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_is_load    <= 1'b0;
      ex_rd         <= '0;
      ex_rs         <= '0;
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_is_load   <= 1'b0;
      mem_rd        <= '0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
      multi_cnt     <= 4'd0;
      stall_cnt_q   <= 32'd0;
    end else begin
      // WB always takes MEM
      wb_valid     <= mem_valid;
      wb_reg_write <= mem_reg_write;
      wb_rd        <= mem_rd;

      if (ex_flush || busy_q) begin
        // squashed or still-running EX op produces nothing downstream yet
        mem_valid     <= 1'b0;
        mem_reg_write <= 1'b0;
        mem_is_load   <= 1'b0;
        mem_rd        <= '0;
      end else begin
        mem_valid     <= ex_valid;
        mem_reg_write <= ex_reg_write;
        mem_is_load   <= ex_is_load;
        mem_rd        <= ex_rd;
      end

      if (ex_flush || (!busy_q && load_use)) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_is_load   <= 1'b0;
        ex_rd        <= '0;
        ex_rs        <= '0;
        multi_cnt    <= 4'd0;
      end else if (busy_q) begin
        multi_cnt <= multi_cnt - 4'd1;
      end else begin
        ex_valid     <= id_valid;
        ex_reg_write <= id_reg_write;
        ex_is_load   <= id_is_load;
        ex_rd        <= id_rd;
        ex_rs        <= id_rs;
        multi_cnt    <= (id_valid && id_is_multi) ? MULTI_INIT : 4'd0;
      end

      if (id_valid && !id_ready && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_forward_stall_unit.sv
// tb/tb_forward_stall_unit.sv - directed-vector bench for forward_stall_unit (2-source and 3-source builds)

module tb_forward_stall_unit;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [14:0] id_rs3;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_is_load;
  logic        id_is_multi;
  logic        ex_flush;

  logic        id_ready,  ex_busy;
  logic [3:0]  fwd_sel;
  logic [31:0] stall_count;
  logic        id_ready3, ex_busy3;
  logic [5:0]  fwd_sel3;
  logic [31:0] stall_count3;

  int n_pass;
  int n_total;

  forward_stall_unit #(.NUM_SRC(2), .REG_AW(5), .MULTI_LAT(4)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_multi(id_is_multi),
    .ex_flush(ex_flush), .id_ready(id_ready), .fwd_sel(fwd_sel), .ex_busy(ex_busy),
    .stall_count(stall_count)
  );

  forward_stall_unit #(.NUM_SRC(3), .REG_AW(5), .MULTI_LAT(4)) u_dut3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs3), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_multi(id_is_multi),
    .ex_flush(ex_flush), .id_ready(id_ready3), .fwd_sel(fwd_sel3), .ex_busy(ex_busy3),
    .stall_count(stall_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                       input logic ld, input logic mu);
    id_valid     = v;
    id_rs        = {rs1, rs0};
    id_rs3       = {rs2, rs1, rs0};
    id_rd        = rd;
    id_reg_write = rw;
    id_is_load   = ld;
    id_is_multi  = mu;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst      = 1'b1;
    ex_flush = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    repeat (2) next();
    mid();
    check("rst_id_ready", id_ready, 0);
    check("rst_ex_busy", ex_busy, 0);
    check("rst_fwd_sel", fwd_sel, 0);
    check("rst_stall_count", stall_count, 0);
    next();
    rst = 1'b0;
    nop();
    mid();
    check("post_rst_id_ready", id_ready, 1);
    next();

    // load x5 then add x6,x5,x7
    drive(1'b1, 5'd1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    mid(); check("lu_load_ready", id_ready, 1); next();
    drive(1'b1, 5'd5, 5'd7, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    mid(); check("lu_stall", id_ready, 0); next();
    mid(); check("lu_release", id_ready, 1); next();
    nop();
    mid();
    check("lu_fwd_wb", fwd_sel, 4'b0001);
    check("lu_stall_count", stall_count, 1);
    next();

    // add x3,x1,x2 ; sub x4,x3,x3 ; or x8,x3,x0
    drive(1'b1, 5'd1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    mid(); check("alu_add_ready", id_ready, 1); next();
    drive(1'b1, 5'd3, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    mid(); check("alu_sub_no_stall", id_ready, 1); next();
    drive(1'b1, 5'd3, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    mid(); check("alu_sub_fwd_mem", fwd_sel, 4'b1010); next();
    nop();
    mid(); check("alu_or_fwd_wb", fwd_sel, 4'b0001); next();

    // two writes to x9, then read x9 on both sources
    drive(1'b1, 5'd0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0); next();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0); next();
    drive(1'b1, 5'd9, 5'd9, 5'd0, 5'd15, 1'b1, 1'b0, 1'b0); next();
    nop();
    mid(); check("x9_mem_priority", fwd_sel, 4'b1010); next();

    // write to x0 never forwards
    drive(1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); next();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0); next();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
    mid(); check("x0_mem", fwd_sel, 0); next();
    nop();
    mid(); check("x0_wb", fwd_sel, 0); next();

    // multi op writing x11, then dependent add
    drive(1'b1, 5'd1, 5'd2, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1);
    mid(); check("multi_accept", id_ready, 1); next();
    drive(1'b1, 5'd11, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      mid();
      check("multi_busy", ex_busy, 1);
      check("multi_hold", id_ready, 0);
      next();
    end
    mid();
    check("multi_done", ex_busy, 0);
    check("multi_release", id_ready, 1);
    next();
    nop();
    mid();
    check("multi_fwd_mem", fwd_sel, 4'b0010);
    check("multi_stall_count", stall_count, 4);
    next();

    // flush during a multi op writing x13
    drive(1'b1, 5'd1, 5'd2, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1); next();
    nop();
    mid(); check("flush_pre_busy", ex_busy, 1); next();
    ex_flush = 1'b1;
    drive(1'b1, 5'd13, 5'd0, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0);
    mid(); check("flush_ready", id_ready, 1); next();
    ex_flush = 1'b0;
    drive(1'b1, 5'd13, 5'd0, 5'd0, 5'd16, 1'b1, 1'b0, 1'b0);
    mid();
    check("flush_busy_cleared", ex_busy, 0);
    check("flush_after_ready", id_ready, 1);
    check("flush_stall_count", stall_count, 4);
    next();
    nop();
    mid(); check("flush_no_fwd", fwd_sel, 0); next();

    // three-source build: third source reads x31 from WB
    drive(1'b1, 5'd0, 5'd0, 5'd0, 5'd31, 1'b1, 1'b0, 1'b0); next();
    nop(); next();
    drive(1'b1, 5'd1, 5'd2, 5'd31, 5'd17, 1'b1, 1'b0, 1'b0); next();
    nop();
    mid();
    check("src3_fwd_wb", fwd_sel3, 6'b010000);
    check("src3_two_src_build", fwd_sel, 0);
    next();

    // reset in the middle of a load-use stall
    drive(1'b1, 5'd0, 5'd0, 5'd0, 5'd20, 1'b1, 1'b1, 1'b0); next();
    drive(1'b1, 5'd20, 5'd0, 5'd0, 5'd21, 1'b1, 1'b0, 1'b0);
    mid();
    check("rs_stall", id_ready, 0);
    check("rs_stall3", id_ready3, 0);
    next();
    rst = 1'b1;
    next();
    mid();
    check("rs_id_ready", id_ready, 0);
    check("rs_id_ready3", id_ready3, 0);
    check("rs_ex_busy3", ex_busy3, 0);
    check("rs_fwd_sel3", fwd_sel3, 0);
    check("rs_stall_count", stall_count, 0);
    check("rs_stall_count3", stall_count3, 0);
    next();
    rst = 1'b0;
    mid();
    check("rs_no_residual", id_ready, 1);
    check("rs_no_residual3", id_ready3, 1);
    next();
    nop();
    mid(); check("rs_fwd_clear", fwd_sel, 0); next();

    // reset in the middle of a multi op
    drive(1'b1, 5'd1, 5'd2, 5'd0, 5'd22, 1'b1, 1'b0, 1'b1); next();
    nop();
    mid(); check("rm_busy", ex_busy, 1); next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    mid();
    check("rm_busy_cleared", ex_busy, 0);
    check("rm_ready", id_ready, 1);
    check("rm_stall_count", stall_count, 0);
    next();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
